beq_serial_sequencer: RTL and testbench

Bit-serial execution sequencer that feeds the team's existing 1-bit ALU slice (module `ALU`) one operand bit per cycle, LSB first, to perform a WIDTH-bit operation. It sits directly upstream of the slice and also consumes the slice's outputs. It accumulates the result word, zero flag and overflow, then resolves the branch-on-equal decision and next PC for the datapath. One slice is reused across WIDTH cycles instead of instantiating WIDTH slices.

---
 rtl/beq_serial_sequencer_pkg.sv | 29 ++
 rtl/beq_serial_sequencer_alu.sv | 35 +++
 rtl/beq_serial_sequencer.sv | 162 ++++++++++++++++
 tb/tb_beq_serial_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beq_serial_sequencer_pkg.sv
// Shared definitions for the bit-serial branch-on-equal sequencer:
// ALU control codes, slice op encodings, FSM state type and the
// illegal-op check used when a request is accepted.
package beq_serial_sequencer_pkg;

    // Full 4-bit alu_ctl codes {Ainvert, Binvert, Op[1:0]}
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // Op field of the 1-bit slice
    localparam logic [1:0] OP_AND     = 2'b00;
    localparam logic [1:0] OP_OR      = 2'b01;
    localparam logic [1:0] OP_ADD     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic ctl_is_illegal(input logic [3:0] ctl);
        return (ctl[1:0] == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/beq_serial_sequencer_alu.sv
// 1-bit ALU slice: optional input inversion, AND / OR / full-add.
// Op=11 (set-less-than in a full ripple ALU) has no meaning for a single
// reused slice, so its result is tied low.
module beq_serial_sequencer_alu
    import beq_serial_sequencer_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ ainvert;
    assign b_eff = b ^ binvert;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    // Select the slice result by op
    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = a_eff ^ b_eff ^ cin;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/beq_serial_sequencer.sv
// Bit-serial sequencer: drives one reused 1-bit ALU slice LSB first over
// WIDTH cycles, accumulates result / zero / overflow, then resolves the
// branch-on-equal decision and next PC.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a start request
// ST_RUN  | one operand bit per cycle through the slice (busy=1)
// ST_DONE | one-cycle done pulse; results valid; may accept a new start
module beq_serial_sequencer
    import beq_serial_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             beq,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] offset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             branch_taken,
    output logic [WIDTH-1:0] next_pc,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    seq_state_t state;
    seq_state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] off_q;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       ctl_q;
    logic             beq_q;
    logic             carry;
    logic             zero_acc;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             illegal_start;
    logic             last_bit;
    logic             slice_res;
    logic             slice_cout;
    logic             zero_nx;
    logic [WIDTH-1:0] result_nx;

    beq_serial_sequencer_alu u_alu (
        .a       (a_q[idx]),
        .b       (b_q[idx]),
        .cin     (carry),
        .ainvert (ctl_q[3]),
        .binvert (ctl_q[2]),
        .op      (ctl_q[1:0]),
        .result  (slice_res),
        .cout    (slice_cout)
    );

    assign last_bit  = (state == ST_RUN) && (idx == LAST_IDX);
    assign zero_nx   = zero_acc & ~slice_res;
    assign result_nx = {slice_res, res_sh[WIDTH-1:1]};
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and request acceptance; start is ignored while running
    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        illegal_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (ctl_is_illegal(alu_ctl)) begin
                        illegal_start = 1'b1;
                        state_nx      = ST_IDLE;
                    end else begin
                        accept   = 1'b1;
                        state_nx = ST_RUN;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx == LAST_IDX) begin
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand latch, serial accumulation and result resolution on the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            pc_q         <= '0;
            off_q        <= '0;
            res_sh       <= '0;
            ctl_q        <= '0;
            beq_q        <= 1'b0;
            carry        <= 1'b0;
            zero_acc     <= 1'b0;
            idx          <= '0;
            result       <= '0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            branch_taken <= 1'b0;
            next_pc      <= '0;
            err          <= 1'b0;
        end else begin
            err <= illegal_start;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                pc_q     <= pc_plus4;
                off_q    <= offset;
                ctl_q    <= alu_ctl;
                beq_q    <= beq;
                carry    <= alu_ctl[2];
                idx      <= '0;
                zero_acc <= 1'b1;
                res_sh   <= '0;
            end else if (state == ST_RUN) begin
                res_sh   <= result_nx;
                carry    <= slice_cout;
                zero_acc <= zero_nx;
                idx      <= idx + 1'b1;
                if (last_bit) begin
                    // carry currently holds the carry into the MSB
                    result       <= result_nx;
                    zero         <= zero_nx;
                    overflow     <= (ctl_q[1:0] == OP_ADD) ? (slice_cout ^ carry) : 1'b0;
                    branch_taken <= beq_q & zero_nx;
                    next_pc      <= (beq_q & zero_nx) ? (pc_q + (off_q << 2)) : pc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_beq_serial_sequencer.sv
// Self-checking bench for beq_serial_sequencer: a reference model pushes
// expected results into a scoreboard when an operation is issued; a
// monitor pops and compares whenever done pulses.
module tb_beq_serial_sequencer;
    import beq_serial_sequencer_pkg::*;

    localparam int W = 32;
    localparam logic [3:0] CTL_ILL = 4'b0011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   alu_ctl = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         beq = 1'b0;
    logic [W-1:0] pc_plus4 = '0;
    logic [W-1:0] offset = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         branch_taken;
    logic [W-1:0] next_pc;
    logic         err;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         overflow;
        logic         taken;
        logic [W-1:0] next_pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_issue = 0;

    beq_serial_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .alu_ctl      (alu_ctl),
        .a            (a),
        .b            (b),
        .beq          (beq),
        .pc_plus4     (pc_plus4),
        .offset       (offset),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .zero         (zero),
        .overflow     (overflow),
        .branch_taken (branch_taken),
        .next_pc      (next_pc),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] op_a,
                                   input logic [W-1:0] op_b, input logic is_beq,
                                   input logic [W-1:0] pc, input logic [W-1:0] off);
        exp_t e;
        logic [W-1:0] r;
        logic ov;
        r  = '0;
        ov = 1'b0;
        case (ctl)
            CTL_AND: r = op_a & op_b;
            CTL_OR:  r = op_a | op_b;
            CTL_NOR: r = ~(op_a | op_b);
            CTL_ADD: begin
                r  = op_a + op_b;
                ov = (op_a[W-1] == op_b[W-1]) && (r[W-1] != op_a[W-1]);
            end
            CTL_SUB: begin
                r  = op_a - op_b;
                ov = (op_a[W-1] != op_b[W-1]) && (r[W-1] != op_a[W-1]);
            end
            default: r = '0;
        endcase
        e.result   = r;
        e.zero     = (r == '0);
        e.overflow = ov;
        e.taken    = is_beq && (r == '0);
        e.next_pc  = e.taken ? (pc + (off << 2)) : pc;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending operation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no pending operation", cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.result) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h expected %h", result, e.result);
                end
                n_checks++;
                if ({zero, overflow, branch_taken, next_pc} !== {e.zero, e.overflow, e.taken, e.next_pc}) begin
                    n_fail++;
                    $display("FAIL sb_flags: got zero=%b ovf=%b taken=%b npc=%h expected zero=%b ovf=%b taken=%b npc=%h",
                             zero, overflow, branch_taken, next_pc, e.zero, e.overflow, e.taken, e.next_pc);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] ctl, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic is_beq, input logic [W-1:0] pc, input logic [W-1:0] off,
                         input bit push);
        @(negedge clk);
        alu_ctl  = ctl;
        a        = op_a;
        b        = op_b;
        beq      = is_beq;
        pc_plus4 = pc;
        offset   = off;
        start    = 1'b1;
        t_issue  = cyc;
        if (push) sb.push_back(model(ctl, op_a, op_b, is_beq, pc, off));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        while (done !== 1'b1 && (cyc - t_issue) < budget) @(negedge clk);
        if (done !== 1'b1 && sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/err=%b expected 000", {busy, done, err});
        end
        n_checks++;
        if ({zero, overflow, branch_taken} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: zero/ovf/taken=%b expected 000", {zero, overflow, branch_taken});
        end
        n_checks++;
        if (result !== '0 || next_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_words: result=%h next_pc=%h expected 0", result, next_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sub_equal;
        issue(CTL_SUB, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0100, 32'h0000_0004, 1'b1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        wait_done(60);
        n_checks++;
        if (done !== 1'b1 || (cyc - t_issue) != W + 1) begin
            n_fail++;
            $display("FAIL latency_sub_eq: done=%b after %0d cycles, expected done=1 after %0d", done, cyc - t_issue, W + 1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
        n_checks++;
        if (result !== 32'h0 || next_pc !== 32'h0000_0110 || branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_eq_const: result=%h npc=%h taken=%b expected 0 00000110 1", result, next_pc, branch_taken);
        end
    endtask

    task automatic test_sub_ne;
        issue(CTL_SUB, 32'd5, 32'd3, 1'b1, 32'h0000_2000, 32'h0000_0010, 1'b1);
        wait_done(60);
        n_checks++;
        if (result !== 32'd2 || branch_taken !== 1'b0 || next_pc !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL sub_5_3: result=%h taken=%b npc=%h expected 2 0 00002000", result, branch_taken, next_pc);
        end
        issue(CTL_SUB, 32'd3, 32'd5, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
        wait_done(60);
        n_checks++;
        if (result !== 32'hFFFF_FFFE || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_3_5: result=%h ovf=%b expected fffffffe 0", result, overflow);
        end
    endtask

    task automatic test_add_overflow;
        issue(CTL_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h0000_0300, 32'h0000_0001, 1'b1);
        wait_done(60);
        n_checks++;
        if (result !== 32'h8000_0000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ovf: result=%h ovf=%b expected 80000000 1", result, overflow);
        end
        // SUB overflow and branch with negative offset, checked through the scoreboard
        issue(CTL_SUB, 32'h8000_0000, 32'h1, 1'b0, 32'h0000_0400, 32'h0, 1'b1);
        wait_done(60);
        issue(CTL_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0000_1000, 32'hFFFF_FFF0, 1'b1);
        wait_done(60);
    endtask

    task automatic test_logic;
        logic [3:0]   ctls [3];
        logic [W-1:0] want [3];
        ctls[0] = CTL_AND; want[0] = 32'h00F0_000F;
        ctls[1] = CTL_OR;  want[1] = 32'hFFF0_0FFF;
        ctls[2] = CTL_NOR; want[2] = 32'h000F_F000;
        for (int i = 0; i < 3; i++) begin
            issue(ctls[i], 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h0000_0500, 32'h0, 1'b1);
            wait_done(60);
            n_checks++;
            if (result !== want[i] || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL logic_%0d: result=%h ovf=%b expected %h 0", i, result, overflow, want[i]);
            end
        end
    endtask

    task automatic test_illegal;
        @(negedge clk);
        alu_ctl = CTL_ILL;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: err=%b busy=%b done=%b expected 1 0 0", err, busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_after: err=%b busy=%b expected 0 0", err, busy);
        end
    endtask

    task automatic test_start_mid_run;
        issue(CTL_ADD, 32'h0000_1111, 32'h0000_2222, 1'b0, 32'h0000_0600, 32'h0, 1'b1);
        repeat (4) @(negedge clk);
        alu_ctl = CTL_ILL;
        a       = 32'hDEAD_BEEF;
        start   = 1'b1;
        @(negedge clk);
        alu_ctl = CTL_SUB;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_start: err=%b busy=%b expected 0 1", err, busy);
        end
        wait_done(60);
        n_checks++;
        if (done !== 1'b1 || (cyc - t_issue) != W + 1) begin
            n_fail++;
            $display("FAIL latency_mid_run: done=%b after %0d cycles, expected %0d", done, cyc - t_issue, W + 1);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        issue(CTL_OR, 32'h0000_00A0, 32'h0000_000B, 1'b0, 32'h0000_0700, 32'h0, 1'b1);
        wait_done(60);
        n_checks++;
        if (done !== 1'b1 || (cyc - t_issue) != W + 1) begin
            n_fail++;
            $display("FAIL latency_b2b_first: done=%b after %0d cycles, expected %0d", done, cyc - t_issue, W + 1);
        end
        alu_ctl  = CTL_ADD;
        a        = 32'h0102_0304;
        b        = 32'h1010_1010;
        beq      = 1'b0;
        pc_plus4 = 32'h0000_0800;
        offset   = 32'h0;
        start    = 1'b1;
        t_issue  = cyc;
        sb.push_back(model(CTL_ADD, 32'h0102_0304, 32'h1010_1010, 1'b0, 32'h0000_0800, 32'h0));
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        wait_done(60);
        n_checks++;
        if (done !== 1'b1 || (cyc - t_issue) != W + 1) begin
            n_fail++;
            $display("FAIL latency_b2b_second: done=%b after %0d cycles, expected %0d", done, cyc - t_issue, W + 1);
        end
    endtask

    task automatic test_reset_mid_run;
        bit saw_done;
        issue(CTL_ADD, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 32'h0000_0900, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || next_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h npc=%h expected 0 0 0 0", busy, done, result, next_pc);
        end
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_no_done: done pulsed after mid-run reset, expected none");
        end
        issue(CTL_SUB, 32'h0000_0042, 32'h0000_0042, 1'b1, 32'h0000_0A00, 32'hFFFF_FFFE, 1'b1);
        wait_done(60);
        n_checks++;
        if (done !== 1'b1 || (cyc - t_issue) != W + 1) begin
            n_fail++;
            $display("FAIL latency_after_reset: done=%b after %0d cycles, expected %0d", done, cyc - t_issue, W + 1);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sub_equal();
        test_sub_ne();
        test_add_overflow();
        test_logic();
        test_illegal();
        test_start_mid_run();
        test_back_to_back();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d operations never completed, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
